// File: rtl/fp_issue_queue.sv
// fp_issue_queue: FP reservation station that buffers dispatched instructions,
// captures missing operands from the CDB and issues ready ones to the FPU.
module fp_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int EU_CTL_LEN  = 4,
    parameter int FLEN        = 64,
    parameter int ROB_IDX_LEN = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [EU_CTL_LEN-1:0]  issue_ctl_i,
    input  logic [2:0]             issue_rm_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i,
    input  logic                   issue_rs1_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i,
    input  logic [FLEN-1:0]        issue_rs1_value_i,
    input  logic                   issue_rs2_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i,
    input  logic [FLEN-1:0]        issue_rs2_value_i,
    input  logic                   issue_rs3_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs3_idx_i,
    input  logic [FLEN-1:0]        issue_rs3_value_i,
    input  logic                   cdb_valid_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_idx_i,
    input  logic [FLEN-1:0]        cdb_value_i,
    output logic                   eu_valid_o,
    input  logic                   eu_ready_i,
    output logic [EU_CTL_LEN-1:0]  eu_ctl_o,
    output logic [2:0]             eu_rm_o,
    output logic [ROB_IDX_LEN-1:0] eu_rob_idx_o,
    output logic [FLEN-1:0]        eu_rs1_value_o,
    output logic [FLEN-1:0]        eu_rs2_value_o,
    output logic [FLEN-1:0]        eu_rs3_value_o
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {EMPTY, WAIT_OPS, READY} state_t;

    state_t                 state_q [DEPTH];
    state_t                 state_d [DEPTH];
    logic [EU_CTL_LEN-1:0]  ctl_q   [DEPTH];
    logic [2:0]             rm_q    [DEPTH];
    logic [ROB_IDX_LEN-1:0] rob_q   [DEPTH];
    logic [2:0]             rdy_q   [DEPTH];
    logic [2:0]             cap     [DEPTH];
    logic [ROB_IDX_LEN-1:0] idx_q   [DEPTH][3];
    logic [FLEN-1:0]        val_q   [DEPTH][3];

    logic [2:0]             in_rdy;
    logic [2:0]             in_hit;
    logic [ROB_IDX_LEN-1:0] in_idx [3];
    logic [FLEN-1:0]        in_val [3];

    logic          alloc, hs, sel_valid, lock_q;
    logic [IW-1:0] alloc_idx, sel_idx, lock_idx_q;

    assign in_rdy = {issue_rs3_ready_i, issue_rs2_ready_i, issue_rs1_ready_i};
    assign in_idx = '{issue_rs1_idx_i, issue_rs2_idx_i, issue_rs3_idx_i};
    assign in_val = '{issue_rs1_value_i, issue_rs2_value_i, issue_rs3_value_i};

    // Free-slot and issue selection look only at registered state, so eu_* never
    // depends combinationally on cdb_* or issue_*.
    always_comb begin
        issue_ready_o = 1'b0;
        alloc_idx     = '0;
        sel_valid     = lock_q;
        sel_idx       = lock_q ? lock_idx_q : '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == EMPTY) begin
                issue_ready_o = 1'b1;
                alloc_idx     = IW'(i);
            end
            if (!lock_q && state_q[i] == READY) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign alloc = issue_valid_i & issue_ready_o;
    assign hs    = sel_valid & eu_ready_i;

    always_comb begin
        for (int j = 0; j < 3; j++)
            in_hit[j] = ~in_rdy[j] & cdb_valid_i & (cdb_idx_i == in_idx[j]);
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < 3; j++)
                cap[i][j] = (state_q[i] == WAIT_OPS) & ~rdy_q[i][j] & cdb_valid_i &
                            (cdb_idx_i == idx_q[i][j]);
            state_d[i] = flush_i ? EMPTY
                : (state_q[i] == EMPTY && alloc && alloc_idx == IW'(i)) ? (&(in_rdy | in_hit) ? READY : WAIT_OPS)
                : (state_q[i] == WAIT_OPS && &(rdy_q[i] | cap[i])) ? READY
                : (state_q[i] == READY && hs && sel_idx == IW'(i)) ? EMPTY
                : state_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++)
            state_q[i] <= rst_i ? EMPTY : state_d[i];
    end

    // The lock pins the offered entry until it is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || hs) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (sel_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc && alloc_idx == IW'(i) && !flush_i) begin
                ctl_q[i] <= issue_ctl_i;
                rm_q[i]  <= issue_rm_i;
                rob_q[i] <= issue_rob_idx_i;
                rdy_q[i] <= in_rdy | in_hit;
                for (int j = 0; j < 3; j++) begin
                    idx_q[i][j] <= in_idx[j];
                    val_q[i][j] <= in_rdy[j] ? in_val[j] : cdb_value_i;
                end
            end else begin
                for (int j = 0; j < 3; j++) begin
                    if (cap[i][j]) begin
                        rdy_q[i][j] <= 1'b1;
                        val_q[i][j] <= cdb_value_i;
                    end
                end
            end
        end
    end

    assign eu_valid_o     = sel_valid;
    assign eu_ctl_o       = sel_valid ? ctl_q[sel_idx] : '0;
    assign eu_rm_o        = sel_valid ? rm_q[sel_idx] : '0;
    assign eu_rob_idx_o   = sel_valid ? rob_q[sel_idx] : '0;
    assign eu_rs1_value_o = sel_valid ? val_q[sel_idx][0] : '0;
    assign eu_rs2_value_o = sel_valid ? val_q[sel_idx][1] : '0;
    assign eu_rs3_value_o = sel_valid ? val_q[sel_idx][2] : '0;
endmodule
